// File: rtl/ov7670_capture.sv
// ov7670_capture: turns the OV7670 RGB565 byte stream into RGB888 pixels.
// Each pixel is tagged with the linear frame-buffer address y*H_ACTIVE+x.
// A small valid/ready FIFO decouples the output; overflowing pixels are dropped.
// Optional build macro CAPTURE_TESTPATTERN_EN replaces the camera data with
// 8 vertical colour bars selected by x[9:7].
module ov7670_capture #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_data,
  output logic [23:0]       o_pixel,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_start,
  output logic              o_frame_done,
  output logic              o_overflow
);

  localparam int unsigned X_W   = $clog2(H_ACTIVE + 1);
  localparam int unsigned Y_W   = $clog2(V_ACTIVE + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 24 + ADDR_W;

  localparam logic [X_W-1:0]    X_MAX  = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]    Y_MAX  = Y_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SYNC        = 2'd0,
    ST_WAIT_VS_LOW = 2'd1,
    ST_ACTIVE      = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_vs, r_hr, r_vs_d, r_hr_d;
  logic [7:0] r_d;
  logic w_vs_rise, w_vs_fall, w_hr_fall;

  logic w_frame_start_c, w_frame_done_c, w_capture_c;
  logic r_frame_start, r_frame_done, r_overflow;

  logic              r_phase;
  logic [7:0]        r_hi;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] w_next_base;
  logic              w_form, w_emit;
  logic [23:0]       w_pixel;

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_valid;
  logic             w_full, w_push, w_pop, w_drop;

  // Register camera pins once, keep a second copy for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs   <= 1'b0;
      r_hr   <= 1'b0;
      r_d    <= 8'd0;
      r_vs_d <= 1'b0;
      r_hr_d <= 1'b0;
    end else begin
      r_vs   <= i_vsync;
      r_hr   <= i_href;
      r_d    <= i_data;
      r_vs_d <= r_vs;
      r_hr_d <= r_hr;
    end
  end

  assign w_vs_rise = r_vs & ~r_vs_d;
  assign w_vs_fall = ~r_vs & r_vs_d;
  assign w_hr_fall = ~r_hr & r_hr_d;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_SYNC;
    else          r_state <= w_state_next;
  end

  // FSM next state: only whole frames (seen from a VSYNC rise) are captured
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SYNC:        if (w_vs_rise) w_state_next = ST_WAIT_VS_LOW;
      ST_WAIT_VS_LOW: if (w_vs_fall) w_state_next = ST_ACTIVE;
      ST_ACTIVE:      if (w_vs_rise) w_state_next = ST_WAIT_VS_LOW;
      default:        w_state_next = ST_SYNC;
    endcase
  end

  // FSM outputs: frame markers and capture enable
  always_comb begin
    w_frame_start_c = 1'b0;
    w_frame_done_c  = 1'b0;
    w_capture_c     = 1'b0;
    case (r_state)
      ST_WAIT_VS_LOW: w_frame_start_c = w_vs_fall;
      ST_ACTIVE: begin
        w_capture_c    = 1'b1;
        w_frame_done_c = w_vs_rise;
      end
      default: ;
    endcase
  end

  assign w_form      = w_capture_c & r_hr & r_phase;
  assign w_emit      = w_form & (r_x < X_MAX) & (r_y < Y_MAX);
  assign w_next_base = r_line_base + H_STEP;

`ifdef CAPTURE_TESTPATTERN_EN
  logic [9:0] w_xb;
  logic [2:0] w_bar;
  assign w_xb    = 10'(r_x);
  assign w_bar   = w_xb[9:7];
  assign w_pixel = {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
`else
  logic [15:0] w_rgb565;
  assign w_rgb565 = {r_hi, r_d};
  assign w_pixel  = {w_rgb565[15:11], w_rgb565[15:13],
                     w_rgb565[10:5],  w_rgb565[10:9],
                     w_rgb565[4:0],   w_rgb565[4:2]};
`endif

  // Byte pairing, x/y position and running address with line base
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase     <= 1'b0;
      r_hi        <= 8'd0;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_line_base <= '0;
    end else if (w_frame_start_c) begin
      r_phase     <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_line_base <= '0;
    end else if (w_capture_c) begin
      if (!r_hr) begin
        r_phase <= 1'b0;
        if (w_hr_fall && (r_x != '0)) begin
          r_x <= '0;
          if (r_y < Y_MAX) begin
            r_y         <= r_y + Y_W'(1);
            r_line_base <= w_next_base;
            r_addr      <= w_next_base;
          end
        end
      end else begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_hi <= r_d;
        end else begin
          if (r_x < X_MAX) r_x <= r_x + X_W'(1);
          if (w_emit)      r_addr <= r_addr + ADDR_W'(1);
        end
      end
    end
  end

  assign w_pop        = r_valid & i_ready;
  assign w_full       = (r_count == C_FULL);
  assign w_push       = w_emit & (~w_full | w_pop);
  assign w_drop       = w_emit & w_full & ~w_pop;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Output FIFO storage and pointers; only reset flushes it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {w_pixel, r_addr};
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
    end
  end

  // Frame pulses and sticky per-frame overflow flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_frame_start <= w_frame_start_c;
      r_frame_done  <= w_frame_done_c;
      if (w_frame_start_c) r_overflow <= 1'b0;
      else if (w_drop)     r_overflow <= 1'b1;
    end
  end

  assign {o_pixel, o_addr} = r_mem[r_rd];
  assign o_valid           = r_valid;
  assign o_frame_start     = r_frame_start;
  assign o_frame_done      = r_frame_done;
  assign o_overflow        = r_overflow;

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture: random camera bytes against a
// queue-based reference of the expected pixel/address stream.
`timescale 1ns/1ps
module tb_ov7670_capture;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int AW = 19;

`ifdef CAPTURE_TESTPATTERN_EN
  localparam logic [23:0] EXP_RED = 24'h000000;
  localparam logic [23:0] EXP_GRN = 24'h000000;
`else
  localparam logic [23:0] EXP_RED = 24'hFF0000;
  localparam logic [23:0] EXP_GRN = 24'h00FF00;
`endif

  typedef struct packed {
    logic [23:0]   pix;
    logic [AW-1:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    data = 8'd0;
  logic          ready = 1'b1;
  logic [23:0]   pixel;
  logic [AW-1:0] addr;
  logic          valid, fstart, fdone, ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int fs_cnt   = 0;
  int fd_cnt   = 0;
  int pop_cnt  = 0;
  logic [AW-1:0] last_addr = '0;
  exp_t exp_q[$];

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_href(href), .i_data(data),
    .o_pixel(pixel), .o_addr(addr), .o_valid(valid), .i_ready(ready),
    .o_frame_start(fstart), .o_frame_done(fdone), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference pixel value from the RGB565 bit-replication rule (or colour bars)
  function automatic logic [23:0] exp_pix(input logic [7:0] hi, input logic [7:0] lo, input int x);
`ifdef CAPTURE_TESTPATTERN_EN
    int bar;
    bar = (x / 128) % 8;
    exp_pix = {bar[2] ? 8'hFF : 8'h00, bar[1] ? 8'hFF : 8'h00, bar[0] ? 8'hFF : 8'h00};
`else
    int v, r5, g6, b5;
    v  = int'(hi) * 256 + int'(lo);
    r5 = v / 2048;
    g6 = (v / 32) % 64;
    b5 = v % 32;
    exp_pix = {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
`endif
  endfunction

  // Consumer side: every accepted word must match the head of the model queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (fstart) fs_cnt++;
      if (fdone)  fd_cnt++;
      if (valid && ready) begin
        check("output_has_expected_entry", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("pixel", 64'(pixel), 64'(e.pix));
          check("addr", 64'(addr), 64'(e.addr));
        end
        pop_cnt++;
        last_addr = addr;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic h);
    data = d;
    href = h;
    tick();
  endtask

  task automatic drive_pixel(input logic [7:0] hi, input logic [7:0] lo, input int x,
                             input int y, input bit push, input logic [23:0] lit, input bit use_lit);
    exp_t e;
    drive_byte(hi, 1'b1);
    drive_byte(lo, 1'b1);
    if (push && x < H && y < V) begin
      e.pix  = use_lit ? lit : exp_pix(hi, lo, x);
      e.addr = AW'(y * H + x);
      exp_q.push_back(e);
    end
  endtask

  // mode 0: random bytes, 1: F8/00, 2: 07/E0; only the first 'keep' pixels are expected
  task automatic drive_line(input int y, input int npix, input int keep, input bit odd, input int mode);
    logic [7:0] hi, lo;
    for (int x = 0; x < npix; x++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      if (mode == 1) begin hi = 8'hF8; lo = 8'h00; end
      if (mode == 2) begin hi = 8'h07; lo = 8'hE0; end
      drive_pixel(hi, lo, x, y, x < keep, (mode == 1) ? EXP_RED : EXP_GRN, mode != 0);
    end
    if (odd) drive_byte(8'($urandom), 1'b1);
    href = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_begin();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    repeat (3) tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || valid); i++) tick();
    repeat (2) tick();
    check({tag, "_model_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_valid_low"}, 64'(valid), 64'd0);
  endtask

  initial begin
    int p0, f0;
    // Reset values
    repeat (3) tick();
    check("rst_pixel", 64'(pixel), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_frame_start", 64'(fstart), 64'd0);
    check("rst_frame_done", 64'(fdone), 64'd0);
    check("rst_overflow", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    // VSYNC low without a prior high: nothing captured
    drive_line(0, 4, 0, 1'b0, 0);
    drain("partial");
    check("partial_no_start", 64'(fs_cnt), 64'd0);
    check("partial_no_pixels", 64'(pop_cnt), 64'd0);

    // Directed colours and frame pulse timing
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    tick();
    check("frame_start_not_early", 64'(fstart), 64'd0);
    tick();
    check("frame_start_pulse", 64'(fstart), 64'd1);
    tick();
    check("frame_start_one_cycle", 64'(fstart), 64'd0);
    repeat (2) tick();
    drive_line(0, 4, 4, 1'b0, 1);
    drive_line(1, 4, 4, 1'b0, 2);
    vsync = 1'b1;
    tick();
    check("frame_done_not_early", 64'(fdone), 64'd0);
    tick();
    check("frame_done_pulse", 64'(fdone), 64'd1);
    tick();
    check("frame_done_one_cycle", 64'(fdone), 64'd0);
    drain("colours");
    check("colours_count", 64'(pop_cnt), 64'd8);
    check("colours_last_addr", 64'(last_addr), 64'd643);
    check("frame_start_count", 64'(fs_cnt), 64'd1);
    check("frame_done_count", 64'(fd_cnt), 64'd1);

    // Over-long lines with odd trailing byte
    p0 = pop_cnt;
    frame_begin();
    for (int y = 0; y < 3; y++) drive_line(y, 641, H, 1'b1, 0);
    frame_end();
    drain("longline");
    check("longline_count", 64'(pop_cnt - p0), 64'd1920);
    check("longline_last_addr", 64'(last_addr), 64'd1919);

    // Push and pop on a full FIFO in the same cycle: no drop
    frame_begin();
    ready = 1'b0;
    for (int x = 0; x < 4; x++) drive_pixel(8'($urandom), 8'($urandom), x, 0, 1'b1, 24'h0, 1'b0);
    drive_pixel(8'($urandom), 8'($urandom), 4, 0, 1'b1, 24'h0, 1'b0);
    ready = 1'b1;
    for (int x = 5; x < 8; x++) drive_pixel(8'($urandom), 8'($urandom), x, 0, 1'b1, 24'h0, 1'b0);
    href = 1'b0;
    repeat (4) tick();
    check("full_pushpop_no_overflow", 64'(ovf), 64'd0);
    frame_end();
    drain("pushpop");
    check("pushpop_overflow_still_low", 64'(ovf), 64'd0);

    // Overflow: 10 pixels with consumer stalled, 4 held and 6 dropped
    frame_begin();
    ready = 1'b0;
    drive_line(0, 10, 4, 1'b0, 0);
    check("overflow_set", 64'(ovf), 64'd1);
    check("overflow_valid_held", 64'(valid), 64'd1);
    frame_end();
    check("overflow_held_past_done", 64'(ovf), 64'd1);
    ready = 1'b1;
    drain("overflow");
    check("overflow_held_until_start", 64'(ovf), 64'd1);
    frame_begin();
    check("overflow_cleared_at_start", 64'(ovf), 64'd0);
    drive_line(0, 6, H, 1'b0, 0);
    frame_end();
    drain("after_overflow");

    // Reset in the middle of a line
    frame_begin();
    ready = 1'b0;
    for (int x = 0; x < 3; x++) drive_pixel(8'($urandom), 8'($urandom), x, 0, 1'b0, 24'h0, 1'b0);
    drive_byte(8'($urandom), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", 64'(valid), 64'd0);
    check("midreset_pixel", 64'(pixel), 64'd0);
    check("midreset_overflow", 64'(ovf), 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    p0 = pop_cnt;
    f0 = fs_cnt;
    for (int x = 0; x < 6; x++) drive_pixel(8'($urandom), 8'($urandom), x, 0, 1'b0, 24'h0, 1'b0);
    href = 1'b0;
    repeat (4) tick();
    drain("postreset");
    check("postreset_no_pixels", 64'(pop_cnt - p0), 64'd0);
    check("postreset_no_start", 64'(fs_cnt - f0), 64'd0);
    frame_begin();
    check("postreset_start_after_vsync", 64'(fs_cnt - f0), 64'd1);
    drive_line(0, 5, H, 1'b0, 0);
    drive_line(1, 3, H, 1'b1, 0);
    frame_end();
    drain("restart");
    check("restart_count", 64'(pop_cnt - p0), 64'd8);

    // Random frame shapes
    for (int f = 0; f < 3; f++) begin
      int nl;
      nl = int'($urandom_range(1, 4));
      frame_begin();
      for (int y = 0; y < nl; y++)
        drive_line(y, int'($urandom_range(1, 12)), H, 1'($urandom_range(0, 1)), 0);
      frame_end();
      drain("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Converts the OV7670 parallel pixel bus (PCLK/VSYNC/HREF/D[7:0], RGB565 two bytes per pixel) into 24-bit RGB888 pixel words, each tagged with a linear frame-buffer address. It sits between the camera pins and the frame buffer / SDRAM write port, clocked directly by the camera pixel clock. A small FIFO with valid/ready decouples the output; on overflow it drops pixels and flags the drop.

## Interface
- H_ACTIVE, 640, pixels per line kept; extra pixels discarded
- V_ACTIVE, 480, lines per frame kept; extra lines discarded
- ADDR_W, 19, width of o_addr (must hold H_ACTIVE*V_ACTIVE-1)
- FIFO_DEPTH, 4, output FIFO entries, power of two, ≥2

- i_clk  in  1  pixel clock (driven from ov7670_pclk)
- i_rst_n  in  1  asynchronous, active-low reset
- i_vsync  in  1  camera VSYNC, high = vertical blanking
- i_href  in  1  camera HREF, high = active line bytes
- i_data  in  8  camera data byte
- o_pixel  out  24  {R8,G8,B8}
- o_addr  out  ADDR_W  linear address y*H_ACTIVE+x
- o_valid  out  1  FIFO head valid
- i_ready  in  1  consumer accepts head when o_valid&i_ready
- o_frame_start  out  1  one-cycle pulse, new frame capture begins
- o_frame_done  out  1  one-cycle pulse, frame capture ends
- o_overflow  out  1  sticky: pixel dropped this frame

## Operation
- Input stage: i_vsync, i_href, i_data registered once; all logic uses registered copies (vs_r, hr_r, d_r); edges detected against a second delayed copy.
- FSM: SYNC → WAIT_VS_LOW → ACTIVE.
  - SYNC (reset state): wait for vs_r rising; partial frame after reset is never captured. → WAIT_VS_LOW.
  - WAIT_VS_LOW: on vs_r falling: clear x, y, address, byte phase, o_overflow; pulse o_frame_start; → ACTIVE.
  - ACTIVE: capture. On vs_r rising: pulse o_frame_done, → WAIT_VS_LOW.
- Byte pairing (ACTIVE, hr_r high): phase 0 latches high byte; phase 1 forms RGB565 = {hi,d_r}, emits pixel, phase toggles back. Phase forced 0 whenever hr_r low; a trailing odd byte is discarded.
- Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Pixel emitted only if x<H_ACTIVE and y<V_ACTIVE; x increments on every formed pixel, saturating at H_ACTIVE.
- On hr_r falling with x>0: y increments (saturate at V_ACTIVE), x←0. Address counter increments per written pixel and, at line end, jumps to y*H_ACTIVE (kept as a running line-base register; no multiplier).
- FIFO: write {pixel,addr} per emitted pixel; pop on o_valid&i_ready. Write when full: pixel dropped, o_overflow←1 (held until next frame start). Simultaneous push and pop when full: both occur, no drop.
- FIFO contents survive frame boundaries; only reset flushes.

## Timing
- Reset: o_pixel=0, o_addr=0, o_valid=0, o_frame_start=0, o_frame_done=0, o_overflow=0; FSM=SYNC; FIFO empty.
- Latency: second byte present on i_data at edge k → registered at k, FIFO written at k+1, o_valid high after k+1 if FIFO was empty (2 edges pin-to-output).
- o_frame_start asserts one cycle after the edge sampling VSYNC low (edge detect on registered copy); o_frame_done likewise for VSYNC high.
- Throughput: one pixel per 2 clocks max; FIFO drains 1/clock with i_ready high.
- Reset mid-frame: everything cleared immediately; resumes at SYNC.

## Configuration
- CAPTURE_TESTPATTERN_EN defined: i_data ignored for pixel value; each emitted pixel = 8 vertical colour bars by x[9:7] (bit2→R=FF, bit1→G=FF, bit0→B=FF, else 00); timing, addressing, FIFO unchanged. Undefined: camera data used; pattern logic absent.

## Test plan
- Reset, then VSYNC low without prior high → no frame_start, no pixels; after VSYNC high→low, frame_start pulses once.
- One line of bytes 0xF8,0x00 ×4 → 4 pixels 0xFF0000, addr 0..3; bytes 0x07,0xE0 → 0x00FF00.
- 3 lines of 641 pixels + odd byte, H_ACTIVE=640 → 1920 pixels, last addr 1919, extra pixel and odd byte dropped.
- i_ready low for 10 pixels, FIFO_DEPTH=4 → 4 held, 6 dropped, o_overflow=1; cleared at next frame_start.
- Reset asserted mid-line → o_valid=0 immediately; next captured pixel addr 0 only after full VSYNC high→low.
- With CAPTURE_TESTPATTERN_EN: x=0 → 0x000000, x=128 → 0x0000FF, x=640 line saturates, x=512 → 0xFF0000.
